// File: rtl/ptw_multilevel_arb.sv
// Page-table walker: round-robin arbitration of N_REQ TLB requesters onto one
// memory port, walking LEVELS-deep radix tables with superpage and fault handling.
module ptw_multilevel_arb #(
  parameter int N_REQ    = 2,
  parameter int LEVELS   = 2,
  parameter int VPN_W    = 10,
  parameter int PG_OFF_W = 12,
  localparam int LVL_W   = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          root_base_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  output logic [N_REQ-1:0]     req_ready_o,
  input  logic [32*N_REQ-1:0]  req_vaddr_i,
  output logic [N_REQ-1:0]     resp_valid_o,
  input  logic [N_REQ-1:0]     resp_ready_i,
  output logic [31:0]          resp_pte_o,
  output logic                 resp_fault_o,
  output logic [LVL_W-1:0]     resp_level_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [31:0]          mem_addr_o,
  input  logic                 mem_resp_valid_i,
  output logic                 mem_resp_ready_o,
  input  logic [31:0]          mem_data_i,
  output logic                 busy_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [31:0] VPN_MASK = (32'h1 << VPN_W) - 32'h1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MREQ  = 2'd1;
  localparam logic [1:0] ST_MWAIT = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [31:0]      vaddr_q, vaddr_d;
  logic [31:0]      base_q, base_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      pte_q, pte_d;
  logic             fault_q, fault_d;

  logic [PTR_W:0]   grant_s;
  logic             grant_vld_s;
  logic [PTR_W-1:0] grant_idx_s;
  logic [31:0]      sel_vaddr_s;

  // Byte offset of the PTE selected by the VPN slice for a given level.
  function automatic logic [31:0] vpn_offset(input logic [31:0] va, input logic [LVL_W-1:0] lvl);
    int sh;
    sh = PG_OFF_W + VPN_W * (LEVELS - 1 - int'(lvl));
    return ((va >> sh) & VPN_MASK) << 2;
  endfunction

  // A leaf above the last level must have zero PPN bits below its own page size.
  function automatic logic sp_misaligned(input logic [31:0] pte, input logic [LVL_W-1:0] lvl);
    int          nbits;
    logic [31:0] mask;
    nbits = VPN_W * (LEVELS - 1 - int'(lvl));
    mask  = (32'h1 << nbits) - 32'h1;
    return ((pte >> PG_OFF_W) & mask) != 32'h0;
  endfunction

  // First valid channel at or after ptr; MSB flags that one was found.
  function automatic logic [PTR_W:0] find_grant(input logic [N_REQ-1:0] vld, input logic [PTR_W-1:0] ptr);
    logic [PTR_W:0] res;
    int idx;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (vld[idx]) begin
        res = {1'b1, PTR_W'(idx)};
      end
    end
    return res;
  endfunction

  assign grant_s     = find_grant(req_valid_i, rr_q);
  assign grant_vld_s = grant_s[PTR_W];
  assign grant_idx_s = grant_s[PTR_W-1:0];
  assign sel_vaddr_s = req_vaddr_i[32*grant_idx_s +: 32];

  assign req_ready_o      = (state_q == ST_IDLE && grant_vld_s) ? (N_REQ'(1) << grant_idx_s) : '0;
  assign resp_valid_o     = (state_q == ST_RESP) ? (N_REQ'(1) << owner_q) : '0;
  assign resp_pte_o       = pte_q;
  assign resp_fault_o     = fault_q;
  assign resp_level_o     = level_q;
  assign mem_req_valid_o  = (state_q == ST_MREQ);
  assign mem_addr_o       = addr_q;
  assign mem_resp_ready_o = (state_q == ST_MWAIT);
  assign busy_o           = (state_q != ST_IDLE);

  // Walk sequencing and PTE classification.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    vaddr_d = vaddr_q;
    base_d  = base_q;
    level_d = level_q;
    addr_d  = addr_q;
    pte_d   = pte_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld_s) begin
          vaddr_d = sel_vaddr_s;
          base_d  = root_base_i;
          owner_d = grant_idx_s;
          level_d = '0;
          rr_d    = (int'(grant_idx_s) >= N_REQ - 1) ? '0 : grant_idx_s + PTR_W'(1);
          addr_d  = root_base_i + vpn_offset(sel_vaddr_s, '0);
          state_d = ST_MREQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MREQ: begin
        if (mem_req_ready_i) begin
          state_d = ST_MWAIT;
        end else begin
          state_d = ST_MREQ;
        end
      end
      ST_MWAIT: begin
        if (!mem_resp_valid_i) begin
          state_d = ST_MWAIT;
        end else if (!mem_data_i[0]) begin
          pte_d   = 32'h0;
          fault_d = 1'b1;
          state_d = ST_RESP;
        end else if (mem_data_i[3:1] != 3'b000) begin
          pte_d   = mem_data_i;
          fault_d = sp_misaligned(mem_data_i, level_q);
          state_d = ST_RESP;
        end else if (int'(level_q) >= LEVELS - 1) begin
          pte_d   = mem_data_i;
          fault_d = 1'b1;
          state_d = ST_RESP;
        end else begin
          base_d  = {mem_data_i[31:PG_OFF_W], {PG_OFF_W{1'b0}}};
          level_d = level_q + LVL_W'(1);
          addr_d  = {mem_data_i[31:PG_OFF_W], {PG_OFF_W{1'b0}}} + vpn_offset(vaddr_q, level_q + LVL_W'(1));
          state_d = ST_MREQ;
        end
      end
      ST_RESP: begin
        if (resp_ready_i[owner_q]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      vaddr_q <= 32'h0;
      base_q  <= 32'h0;
      level_q <= '0;
      addr_q  <= 32'h0;
      pte_q   <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      vaddr_q <= vaddr_d;
      base_q  <= base_d;
      level_q <= level_d;
      addr_q  <= addr_d;
      pte_q   <= pte_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_ptw_multilevel_arb.sv
// Scoreboard bench for ptw_multilevel_arb: directed walks over a small table image,
// memory model checks PTE addresses, monitor checks responses.
module tb_ptw_multilevel_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] root_base_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [63:0] req_vaddr_i;
  logic [1:0]  resp_valid_o;
  logic [1:0]  resp_ready_i;
  logic [31:0] resp_pte_o;
  logic        resp_fault_o;
  logic [0:0]  resp_level_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_resp_valid_i;
  logic        mem_resp_ready_o;
  logic [31:0] mem_data_i;
  logic        busy_o;

  always #5 clk = ~clk;

  ptw_multilevel_arb dut (
    .clk(clk), .rst(rst), .root_base_i(root_base_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_vaddr_i(req_vaddr_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_pte_o(resp_pte_o), .resp_fault_o(resp_fault_o), .resp_level_o(resp_level_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
    .mem_data_i(mem_data_i), .busy_o(busy_o)
  );

  typedef struct {
    int          ch;
    logic [31:0] pte;
    logic        fault;
    logic        lvl;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] addr_exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          req_delay = 0;
  int          resp_delay = 0;
  bit          flush = 1'b0;

  bit          m_req_hs, m_resp_hs, m_pend;
  int          m_rcnt, m_dcnt;
  logic [31:0] m_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0400: return 32'h0000_1001;
      32'h0000_0404: return 32'h1234_0000;
      32'h0000_040C: return 32'h0000_000F;
      32'h0000_0410: return 32'h0000_100F;
      32'h0000_1004: return 32'h1100_000F;
      32'h0000_1008: return 32'h1200_0003;
      32'h0000_1010: return 32'h0000_1001;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  // Memory model: inputs driven on negedge, handshakes predicted for the next posedge.
  initial begin
    m_req_hs = 1'b0; m_resp_hs = 1'b0; m_pend = 1'b0;
    m_rcnt = 0; m_dcnt = 0; m_rdata = 32'h0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_data_i = 32'h0;
    forever begin
      @(negedge clk);
      if (flush) begin
        m_pend = 1'b0; m_req_hs = 1'b0; m_resp_hs = 1'b0; m_rcnt = 0;
        addr_exp_q.delete();
      end
      if (m_req_hs) begin
        m_pend = 1'b1;
        m_dcnt = resp_delay;
      end
      if (m_resp_hs) m_pend = 1'b0;
      if (mem_req_valid_o) begin
        mem_req_ready_i = (m_rcnt >= req_delay);
        m_rcnt++;
      end else begin
        mem_req_ready_i = 1'b0;
        m_rcnt = 0;
      end
      if (m_pend && m_dcnt == 0) begin
        mem_resp_valid_i = 1'b1;
        mem_data_i = m_rdata;
      end else begin
        mem_resp_valid_i = 1'b0;
        mem_data_i = 32'hDEAD_BEEF;
        if (m_pend) m_dcnt--;
      end
      m_req_hs  = mem_req_valid_o && mem_req_ready_i;
      m_resp_hs = mem_resp_valid_i && mem_resp_ready_o;
      if (m_req_hs) begin
        m_rdata = mem_rd(mem_addr_o);
        m_rcnt = 0;
        if (addr_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_addr unexpected request actual=%h required=none", mem_addr_o);
        end else begin
          chk("mem_addr", mem_addr_o, addr_exp_q.pop_front());
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (resp_valid_o & resp_ready_i) != 2'b00) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp unexpected actual=%b required=none", resp_valid_o);
        end else begin
          e = sb_q.pop_front();
          chk("resp_valid", {30'h0, resp_valid_o}, 32'h1 << e.ch);
          chk("resp_pte", resp_pte_o, e.pte);
          chk("resp_fault", {31'h0, resp_fault_o}, {31'h0, e.fault});
          chk("resp_level", {31'h0, resp_level_o}, {31'h0, e.lvl});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL wait_done timeout actual=%0d pending required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic walk(input int ch, input logic [31:0] va, input int naddr,
                      input logic [31:0] a0, input logic [31:0] a1, input bit push_sb,
                      input logic [31:0] pte, input logic fault, input logic lvl, input bit wait_resp);
    exp_t e;
    int   n = 0;
    if (naddr > 0) addr_exp_q.push_back(a0);
    if (naddr > 1) addr_exp_q.push_back(a1);
    if (push_sb) begin
      e.ch = ch; e.pte = pte; e.fault = fault; e.lvl = lvl;
      sb_q.push_back(e);
    end
    req_vaddr_i[32*ch +: 32] = va;
    req_valid_i[ch] = 1'b1;
    #1;
    while (!req_ready_o[ch] && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!req_ready_o[ch]) begin
      errors++;
      $display("FAIL accept timeout ch%0d actual=%b required=grant", ch, req_ready_o);
    end
    tick();
    req_valid_i[ch] = 1'b0;
    if (wait_resp) wait_done();
  endtask

  initial begin
    int n;
    int acc;
    rst = 1'b1; root_base_i = 32'h0000_0400; req_valid_i = 2'b00;
    req_vaddr_i = 64'h0; resp_ready_i = 2'b11;
    tick(); tick();
    req_valid_i = 2'b01;
    #1;
    chk("reset req_ready", {30'h0, req_ready_o}, 32'h1);
    chk("reset resp_valid", {30'h0, resp_valid_o}, 32'h0);
    chk("reset resp_fault", {31'h0, resp_fault_o}, 32'h0);
    chk("reset mem_req_valid", {31'h0, mem_req_valid_o}, 32'h0);
    chk("reset mem_resp_ready", {31'h0, mem_resp_ready_o}, 32'h0);
    chk("reset busy", {31'h0, busy_o}, 32'h0);
    req_valid_i = 2'b00;
    rst = 1'b0;
    tick();

    walk(0, 32'h0000_1000, 2, 32'h0000_0400, 32'h0000_1004, 1'b1, 32'h1100_000F, 1'b0, 1'b1, 1'b1);
    walk(1, 32'h0040_0000, 1, 32'h0000_0404, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    walk(0, 32'h00C0_0000, 1, 32'h0000_040C, 32'h0, 1'b1, 32'h0000_000F, 1'b0, 1'b0, 1'b1);
    walk(1, 32'h0100_0000, 1, 32'h0000_0410, 32'h0, 1'b1, 32'h0000_100F, 1'b1, 1'b0, 1'b1);

    req_delay = 2; resp_delay = 1;
    walk(1, 32'h0000_4000, 2, 32'h0000_0400, 32'h0000_1010, 1'b1, 32'h0000_1001, 1'b1, 1'b1, 1'b1);
    req_delay = 0; resp_delay = 0;

    // Response held back: outputs must stay put until accepted.
    resp_ready_i = 2'b00;
    walk(0, 32'h0100_0000, 1, 32'h0000_0410, 32'h0, 1'b1, 32'h0000_100F, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (resp_valid_o == 2'b00 && n < 50) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold resp_valid", {30'h0, resp_valid_o}, 32'h1);
      chk("hold resp_pte", resp_pte_o, 32'h0000_100F);
      chk("hold resp_fault", {31'h0, resp_fault_o}, 32'h1);
      chk("hold resp_level", {31'h0, resp_level_o}, 32'h0);
      tick();
    end
    resp_ready_i = 2'b11;
    wait_done();

    // Reset in the middle of a walk; the late read data must be ignored.
    resp_delay = 6;
    walk(0, 32'h0000_1000, 1, 32'h0000_0400, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!mem_resp_ready_o && n < 50) begin
      tick();
      n++;
    end
    chk("mid-walk in MWAIT", {31'h0, mem_resp_ready_o}, 32'h1);
    rst = 1'b1;
    tick();
    chk("mid rst busy", {31'h0, busy_o}, 32'h0);
    chk("mid rst mem_resp_ready", {31'h0, mem_resp_ready_o}, 32'h0);
    chk("mid rst mem_req_valid", {31'h0, mem_req_valid_o}, 32'h0);
    chk("mid rst resp_valid", {30'h0, resp_valid_o}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("late data resp_valid", {30'h0, resp_valid_o}, 32'h0);
      chk("late data busy", {31'h0, busy_o}, 32'h0);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    resp_delay = 0;
    tick();

    // Both channels requesting: grants alternate starting from channel 0.
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back('{ch: 0, pte: 32'h0000_000F, fault: 1'b0, lvl: 1'b0});
      addr_exp_q.push_back(32'h0000_040C);
      sb_q.push_back('{ch: 1, pte: 32'h1200_0003, fault: 1'b0, lvl: 1'b1});
      addr_exp_q.push_back(32'h0000_0400);
      addr_exp_q.push_back(32'h0000_1008);
    end
    req_vaddr_i = {32'h0000_2000, 32'h00C0_0000};
    req_valid_i = 2'b11;
    acc = 0;
    n = 0;
    while (acc < 4 && n < 400) begin
      #1;
      if (req_ready_o != 2'b00) begin
        chk("rr grant", {30'h0, req_ready_o}, (acc % 2 == 0) ? 32'h1 : 32'h2);
        acc++;
      end
      tick();
      n++;
    end
    req_valid_i = 2'b00;
    chk("rr accepts", acc, 4);
    wait_done();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
